// File: rtl/ysyx_23060332_mem_arb.sv
// rtl/ysyx_23060332_mem_arb.sv - two-requester (IFU/LSU) arbiter onto one memory port
//
// Purpose: serialises instruction fetches and load/stores onto a single
// request/grant/response memory port, one transaction in flight at a time,
// with a response timeout.
//
// Parameter:
//   TIMEOUT_CYC  cycles to wait in RESP for mem_rvalid before giving up
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ifu_req/addr -> ifu_ack/rdata instruction fetch (read only)
//   lsu_req/wen/addr/wdata/wmask -> lsu_ack/rdata   load/store
//   mem_req/wen/addr/wdata/wmask, mem_gnt            memory request side
//   mem_rvalid/rdata                                 memory response side
//   err                           high in an ack cycle that ended by timeout
//
// Build option:
//   YSYX_23060332_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                            undefined -> fixed priority, LSU wins
module ysyx_23060332_mem_arb #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ack,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_ack,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYC);

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic        err_flag;
    logic        win_lsu;
    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [7:0]  lat_wmask;
    logic [31:0] rdata_q;
    logic        pick_lsu;
    logic        timed_out;

`ifdef YSYX_23060332_ARB_RR_EN
    // 1 when the most recent grant went to the LSU; reset value 0 makes
    // the LSU win the first contended arbitration.
    logic        rr_last_lsu;

    always_comb begin
        pick_lsu = lsu_req && (!ifu_req || !rr_last_lsu);
    end
`else
    always_comb begin
        pick_lsu = lsu_req;
    end
`endif

    // An rvalid in the same cycle as the limit wins: completes normally.
    assign timed_out = !mem_rvalid && (cnt == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ifu_req || lsu_req) state_nxt = REQ;
            REQ:     if (mem_gnt) state_nxt = RESP;
            RESP:    if (mem_rvalid || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            err_flag  <= 1'b0;
            win_lsu   <= 1'b0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            rdata_q   <= '0;
`ifdef YSYX_23060332_ARB_RR_EN
            rr_last_lsu <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_req || lsu_req) begin
                        win_lsu  <= pick_lsu;
                        err_flag <= 1'b0;
                        if (pick_lsu) begin
                            lat_wen   <= lsu_wen;
                            lat_addr  <= lsu_addr;
                            lat_wdata <= lsu_wdata;
                            lat_wmask <= lsu_wmask;
                        end else begin
                            lat_wen   <= 1'b0;
                            lat_addr  <= ifu_addr;
                            lat_wdata <= '0;
                            lat_wmask <= '0;
                        end
`ifdef YSYX_23060332_ARB_RR_EN
                        rr_last_lsu <= pick_lsu;
`endif
                    end
                end
                REQ: begin
                    if (mem_gnt) cnt <= '0;
                end
                RESP: begin
                    if (mem_rvalid) begin
                        rdata_q <= lat_wen ? 32'd0 : mem_rdata;
                    end else if (timed_out) begin
                        rdata_q  <= '0;
                        err_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload is only presented while requesting so idle outputs read 0.
    always_comb begin
        mem_req   = (state == REQ);
        mem_wen   = mem_req ? lat_wen   : 1'b0;
        mem_addr  = mem_req ? lat_addr  : 32'd0;
        mem_wdata = mem_req ? lat_wdata : 32'd0;
        mem_wmask = mem_req ? lat_wmask : 8'd0;
        ifu_ack   = (state == DONE) && !win_lsu;
        lsu_ack   = (state == DONE) &&  win_lsu;
        ifu_rdata = ifu_ack ? rdata_q : 32'd0;
        lsu_rdata = lsu_ack ? rdata_q : 32'd0;
        err       = (state == DONE) && err_flag;
    end

endmodule

// File: tb/tb_ysyx_23060332_mem_arb.sv
// tb/tb_ysyx_23060332_mem_arb.sv - directed self-checking bench for ysyx_23060332_mem_arb
module tb_ysyx_23060332_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_ack;
    logic [31:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_ack;
    logic [31:0] lsu_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060332_mem_arb #(.TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ifu_req    (ifu_req),
        .ifu_addr   (ifu_addr),
        .ifu_ack    (ifu_ack),
        .ifu_rdata  (ifu_rdata),
        .lsu_req    (lsu_req),
        .lsu_wen    (lsu_wen),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_wmask  (lsu_wmask),
        .lsu_ack    (lsu_ack),
        .lsu_rdata  (lsu_rdata),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"},   {31'd0, mem_req},   32'd0);
        chk({tag, "_mem_addr"},  mem_addr,           32'd0);
        chk({tag, "_ifu_ack"},   {31'd0, ifu_ack},   32'd0);
        chk({tag, "_lsu_ack"},   {31'd0, lsu_ack},   32'd0);
        chk({tag, "_ifu_rdata"}, ifu_rdata,          32'd0);
        chk({tag, "_lsu_rdata"}, lsu_rdata,          32'd0);
        chk({tag, "_err"},       {31'd0, err},       32'd0);
    endtask

    // Advance until an ack appears (bounded); reports which port acked.
    task automatic wait_ack(input string tag, output logic got_ifu, output logic got_lsu,
                            output int ncyc);
        ncyc = 0;
        do begin
            cyc();
            ncyc++;
        end while (!(ifu_ack || lsu_ack) && ncyc < 30);
        got_ifu = ifu_ack;
        got_lsu = lsu_ack;
        chk({tag, "_ack_seen"}, {31'd0, ifu_ack | lsu_ack}, 32'd1);
        chk({tag, "_ack_excl"}, {31'd0, ifu_ack & lsu_ack}, 32'd0);
    endtask

    initial begin
        logic gi, gl;
        int   n;
        logic exp_lsu;

        rst = 1'b1; ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_wen = 0;
        lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        cyc(); cyc();
        chk_all_zero("reset");
        rst = 1'b0;

        // Single IFU read at minimum latency.
        ifu_req = 1; ifu_addr = 32'h8000_0000; mem_gnt = 1;
        cyc();
        chk("ifu_mem_req",   {31'd0, mem_req}, 32'd1);
        chk("ifu_mem_addr",  mem_addr, 32'h8000_0000);
        chk("ifu_mem_wen",   {31'd0, mem_wen}, 32'd0);
        chk("ifu_mem_wmask", {24'd0, mem_wmask}, 32'd0);
        mem_rvalid = 1; mem_rdata = 32'h0000_0413;
        cyc();
        chk("ifu_resp_memreq", {31'd0, mem_req}, 32'd0);
        chk("ifu_resp_noack",  {31'd0, ifu_ack}, 32'd0);
        cyc();
        chk("ifu_ack",       {31'd0, ifu_ack}, 32'd1);
        chk("ifu_rdata",     ifu_rdata, 32'h0000_0413);
        chk("ifu_err",       {31'd0, err}, 32'd0);
        chk("ifu_lsu_ack",   {31'd0, lsu_ack}, 32'd0);
        ifu_req = 0; mem_rvalid = 0; mem_gnt = 0;
        cyc();
        chk("ifu_ack_pulse", {31'd0, ifu_ack}, 32'd0);
        chk("ifu_rdata_idle", ifu_rdata, 32'd0);

        // Store with 5 cycles of backpressure; requester changes payload after latch.
        lsu_req = 1; lsu_wen = 1; lsu_addr = 32'h8000_1004;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        cyc();
        lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 8'h01;
        for (int i = 0; i < 5; i++) begin
            chk("st_mem_req",   {31'd0, mem_req}, 32'd1);
            chk("st_mem_wen",   {31'd0, mem_wen}, 32'd1);
            chk("st_mem_addr",  mem_addr, 32'h8000_1004);
            chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_mem_wmask", {24'd0, mem_wmask}, 32'h0F);
            cyc();
        end
        chk("st_still_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1;
        cyc();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        chk("st_resp_memreq", {31'd0, mem_req}, 32'd0);
        cyc();
        chk("st_lsu_ack",   {31'd0, lsu_ack}, 32'd1);
        chk("st_lsu_rdata", lsu_rdata, 32'd0);
        chk("st_ifu_ack",   {31'd0, ifu_ack}, 32'd0);
        lsu_req = 0; lsu_wen = 0; mem_rvalid = 0;
        cyc();
        chk("st_ack_pulse", {31'd0, lsu_ack}, 32'd0);

        // Contention from a fresh reset: both held, memory always ready.
        rst = 1; cyc(); rst = 0;
        ifu_req = 1; ifu_addr = 32'h8000_0100;
        lsu_req = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000; lsu_wmask = 8'h0F;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0000_CAFE;
        for (int i = 0; i < 6; i++) begin
`ifdef YSYX_23060332_ARB_RR_EN
            exp_lsu = (i % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            wait_ack("cont", gi, gl, n);
            chk("cont_winner_lsu", {31'd0, gl}, {31'd0, exp_lsu});
            chk("cont_rdata", exp_lsu ? lsu_rdata : ifu_rdata, 32'h0000_CAFE);
            chk("cont_other_rdata", exp_lsu ? ifu_rdata : lsu_rdata, 32'd0);
        end
        ifu_req = 0; lsu_req = 0; mem_gnt = 0; mem_rvalid = 0;
        cyc(); cyc();
        chk("cont_quiet", {31'd0, mem_req | ifu_ack | lsu_ack}, 32'd0);

        // Timeout (TIMEOUT_CYC=4): no response ever arrives.
        ifu_req = 1; ifu_addr = 32'h8000_0200; mem_gnt = 1;
        wait_ack("to", gi, gl, n);
        chk("to_ifu_ack", {31'd0, gi}, 32'd1);
        chk("to_err",     {31'd0, err}, 32'd1);
        chk("to_rdata",   ifu_rdata, 32'd0);
        chk("to_min_wait", {31'd0, n >= 6}, 32'd1);
        ifu_req = 0; mem_gnt = 0;
        cyc();
        chk("to_err_pulse", {31'd0, err}, 32'd0);
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stray_no_ack", {31'd0, ifu_ack | lsu_ack | mem_req}, 32'd0);
        end
        mem_rvalid = 0;

        // Reset while in RESP aborts without ack.
        lsu_req = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000; mem_gnt = 1;
        cyc();
        cyc();
        chk("rst_in_resp_memreq", {31'd0, mem_req}, 32'd0);
        lsu_req = 0; mem_gnt = 0; rst = 1;
        cyc();
        rst = 0;
        chk_all_zero("rst_abort");
        mem_rvalid = 1; mem_rdata = 32'h5555_5555;
        cyc();
        chk("late_rvalid_no_ack", {31'd0, ifu_ack | lsu_ack}, 32'd0);
        cyc();
        chk("late_rvalid_no_ack2", {31'd0, ifu_ack | lsu_ack}, 32'd0);
        mem_rvalid = 0;
        ifu_req = 1; ifu_addr = 32'h8000_0400; mem_gnt = 1;
        cyc();
        chk("post_rst_addr", mem_addr, 32'h8000_0400);
        mem_rvalid = 1; mem_rdata = 32'h0000_0093;
        wait_ack("post_rst", gi, gl, n);
        chk("post_rst_ifu", {31'd0, gi}, 32'd1);
        chk("post_rst_rdata", ifu_rdata, 32'h0000_0093);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        ifu_req = 0; mem_gnt = 0; mem_rvalid = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
